// File: rtl/cpu_pkg.sv
// Shared types and constants for the register-file access path.
// Holds the state encoding and the read/write and length encodings seen by the register file.
package cpu_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  localparam logic RF_READ  = 1'b1;
  localparam logic RF_WRITE = 1'b0;

  localparam logic LEN_8  = 1'b0;
  localparam logic LEN_16 = 1'b1;

  // WRITE is the only encoding with bit 2 set, so the write strobe can come
  // straight from one flop rather than from a multi-bit compare.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    READ  = 3'b001,
    ISSUE = 3'b010,
    WAIT  = 3'b011,
    WRITE = 3'b100
  } state_t;

endpackage

// File: rtl/timeout_counter.sv
// Counts cycles spent waiting for the ALU.
// Raises expired when the count reaches TIMEOUT-1, then holds that value until cleared.
module timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequences one micro-op through the register file: operand read, ALU hand-off and writeback.
// The writeback is either 8 bits or 16 bits (a register pair).
module regfile_access_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_rs1,
  input  logic [ADDR_W-1:0]   req_rs2,
  input  logic [ADDR_W-1:0]   req_rd,
  input  logic                req_wide,
  input  logic                req_wb_en,
  output logic                op_valid,
  output logic [DATA_W-1:0]   op_a,
  output logic [DATA_W-1:0]   op_b,
  input  logic                result_valid,
  input  logic [2*DATA_W-1:0] result_data,
  output logic [ADDR_W-1:0]   rf_rs1_addr,
  output logic [ADDR_W-1:0]   rf_rs2_addr,
  input  logic [DATA_W-1:0]   rf_rs1_data,
  input  logic [DATA_W-1:0]   rf_rs2_data,
  output logic [ADDR_W-1:0]   rf_rd_addr,
  output logic [2*DATA_W-1:0] rf_rd_data,
  output logic                rf_r_w,
  output logic                rf_input_length,
  output logic                done,
  output logic                err_pair,
  output logic                err_timeout
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  state_t state, state_nx;

  logic [ADDR_W-1:0]   rs1_q, rs2_q, rd_q;
  logic                wide_q, wb_en_q, pair_bad_q;
  logic [2*DATA_W-1:0] wb_data_q;
  logic                done_nx, err_pair_nx, err_timeout_nx;
  logic                expired;

  timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ISSUE),
    .enable  (state == WAIT),
    .expired (expired)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx       = state;
    done_nx        = 1'b0;
    err_pair_nx    = 1'b0;
    err_timeout_nx = 1'b0;
    case (state)
      IDLE:  if (req_valid) state_nx = READ;
      READ:  state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT: begin
        // A result arriving in the expiry cycle still counts as a result.
        if (result_valid) begin
          if (wb_en_q && !pair_bad_q) begin
            state_nx = WRITE;
          end else begin
            state_nx    = IDLE;
            done_nx     = 1'b1;
            err_pair_nx = pair_bad_q & wb_en_q;
          end
        end else if (expired) begin
          state_nx       = IDLE;
          done_nx        = 1'b1;
          err_timeout_nx = 1'b1;
        end
      end
      WRITE: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      wide_q      <= 1'b0;
      wb_en_q     <= 1'b0;
      pair_bad_q  <= 1'b0;
      wb_data_q   <= '0;
      op_a        <= '0;
      op_b        <= '0;
      done        <= 1'b0;
      err_pair    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      done        <= done_nx;
      err_pair    <= err_pair_nx;
      err_timeout <= err_timeout_nx;
      if (state == IDLE && req_valid) begin
        rs1_q      <= req_rs1;
        rs2_q      <= req_rs2;
        rd_q       <= req_rd;
        wide_q     <= req_wide;
        wb_en_q    <= req_wb_en;
        pair_bad_q <= req_wide && (req_rd == LAST_REG);
      end
      if (state == READ) begin
        op_a <= rf_rs1_data;
        op_b <= rf_rs2_data;
      end
      if (state == WAIT && result_valid) begin
        wb_data_q <= wide_q ? result_data
                            : {{DATA_W{1'b0}}, result_data[DATA_W-1:0]};
      end
    end
  end

  assign req_ready       = (state == IDLE);
  assign op_valid        = (state == ISSUE);
  assign rf_rs1_addr     = rs1_q;
  assign rf_rs2_addr     = rs2_q;
  assign rf_rd_addr      = rd_q;
  assign rf_rd_data      = wb_data_q;
  assign rf_r_w          = state[2] ? RF_WRITE : RF_READ;
  assign rf_input_length = (state[2] && wide_q) ? LEN_16 : LEN_8;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: table of micro-ops against a behavioural register file,
// followed by hand-written reset-in-WAIT and back-to-back sequences.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_rs1, req_rs2, req_rd;
  logic        req_wide, req_wb_en;
  logic        op_valid;
  logic [7:0]  op_a, op_b;
  logic        result_valid;
  logic [15:0] result_data;
  logic [2:0]  rf_rs1_addr, rf_rs2_addr, rf_rd_addr;
  logic [7:0]  rf_rs1_data, rf_rs2_data;
  logic [15:0] rf_rd_data;
  logic        rf_r_w, rf_input_length;
  logic        done, err_pair, err_timeout;

  regfile_access_ctrl #(.DATA_W(8), .ADDR_W(3), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_wide(req_wide), .req_wb_en(req_wb_en),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .result_valid(result_valid), .result_data(result_data),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_r_w(rf_r_w), .rf_input_length(rf_input_length),
    .done(done), .err_pair(err_pair), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural 8x8 register file: async read, write on the edge while rf_r_w is low.
  logic [7:0] regs [8];
  logic       rf_init;

  function automatic logic [7:0] init_val(input int i);
    case (i)
      2:       return 8'h11;
      3:       return 8'h22;
      default: return 8'hA0 | 8'(i);
    endcase
  endfunction

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 8; i++) regs[i] <= init_val(i);
    end else if (!rf_r_w) begin
      if (rf_input_length) begin
        regs[rf_rd_addr]        <= rf_rd_data[15:8];
        regs[rf_rd_addr + 3'd1] <= rf_rd_data[7:0];
      end else begin
        regs[rf_rd_addr] <= rf_rd_data[7:0];
      end
    end
  end

  assign rf_rs1_data = regs[rf_rs1_addr];
  assign rf_rs2_data = regs[rf_rs2_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string t);
    check({t, " req_ready"},   32'(req_ready), 32'd1);
    check({t, " rf_r_w"},      32'(rf_r_w), 32'd1);
    check({t, " op_valid"},    32'(op_valid), 32'd0);
    check({t, " op_a"},        32'(op_a), 32'd0);
    check({t, " op_b"},        32'(op_b), 32'd0);
    check({t, " rs1_addr"},    32'(rf_rs1_addr), 32'd0);
    check({t, " rd_addr"},     32'(rf_rd_addr), 32'd0);
    check({t, " rd_data"},     32'(rf_rd_data), 32'd0);
    check({t, " length"},      32'(rf_input_length), 32'd0);
    check({t, " done"},        32'(done), 32'd0);
    check({t, " err_pair"},    32'(err_pair), 32'd0);
    check({t, " err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  rs1, rs2, rd;
    logic        wide, wb_en;
    logic [15:0] result;
    int          k;          // result_valid k cycles after op_valid; 0 = ALU never answers
    logic [7:0]  exp_a, exp_b;
    logic        exp_wr, exp_len;
    logic [15:0] exp_data;
    logic        exp_epair, exp_eto;
    logic [2:0]  c0_addr;
    logic [7:0]  c0_val;
    logic [2:0]  c1_addr;
    logic [7:0]  c1_val;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input int idx, input vec_t v);
    int          issue_cyc = -1;
    int          wr_cyc    = -1;
    int          done_cyc  = -1;
    int          wr_cnt    = 0;
    logic [2:0]  wr_addr   = '0;
    logic [15:0] wr_data   = '0;
    logic        wr_len    = 1'b0;
    logic        ep        = 1'b0;
    logic        eto       = 1'b0;
    logic        rdy_done  = 1'b0;
    string       t         = $sformatf("v%0d", idx);
    @(negedge clk);
    check({t, " ready"}, 32'(req_ready), 32'd1);
    check({t, " done idle"}, 32'(done), 32'd0);
    req_valid   = 1'b1;
    req_rs1     = v.rs1;
    req_rs2     = v.rs2;
    req_rd      = v.rd;
    req_wide    = v.wide;
    req_wb_en   = v.wb_en;
    result_data = v.result;
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      @(negedge clk);
      req_valid    = 1'b0;
      result_valid = 1'b0;
      if (op_valid) begin
        issue_cyc = c;
        check({t, " op_a"}, 32'(op_a), 32'(v.exp_a));
        check({t, " op_b"}, 32'(op_b), 32'(v.exp_b));
      end
      if (!rf_r_w) begin
        wr_cnt++;
        wr_cyc  = c;
        wr_addr = rf_rd_addr;
        wr_data = rf_rd_data;
        wr_len  = rf_input_length;
      end
      if (done) begin
        done_cyc = c;
        ep       = err_pair;
        eto      = err_timeout;
        rdy_done = req_ready;
      end
      if (issue_cyc > 0 && v.k > 0 && c == issue_cyc + v.k) result_valid = 1'b1;
    end
    check({t, " done seen"}, 32'(done_cyc > 0), 32'd1);
    check({t, " ready at done"}, 32'(rdy_done), 32'd1);
    check({t, " write cycles"}, 32'(wr_cnt), v.exp_wr ? 32'd1 : 32'd0);
    if (v.exp_wr) begin
      check({t, " wr addr"}, 32'(wr_addr), 32'(v.rd));
      check({t, " wr data"}, 32'(wr_data), 32'(v.exp_data));
      check({t, " wr len"},  32'(wr_len), 32'(v.exp_len));
      check({t, " done after write"}, 32'(done_cyc - wr_cyc), 32'd1);
    end
    if (v.exp_eto) check({t, " timeout latency"}, 32'(done_cyc - issue_cyc), 32'd17);
    check({t, " err_pair"},    32'(ep),  32'(v.exp_epair));
    check({t, " err_timeout"}, 32'(eto), 32'(v.exp_eto));
    check({t, " reg a"}, 32'(regs[v.c0_addr]), 32'(v.c0_val));
    check({t, " reg b"}, 32'(regs[v.c1_addr]), 32'(v.c1_val));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         rs1   rs2   rd    w  wb  result    k   a      b      wr len data      ep eto c0    v0     c1    v1
    vecs[0] = '{3'd2, 3'd3, 3'd4, 0, 1, 16'h0033, 2, 8'h11, 8'h22, 1, 0, 16'h0033, 0, 0, 3'd4, 8'h33, 3'd5, 8'hA5};
    vecs[1] = '{3'd4, 3'd2, 3'd4, 1, 1, 16'hBEEF, 1, 8'h33, 8'h11, 1, 1, 16'hBEEF, 0, 0, 3'd4, 8'hBE, 3'd5, 8'hEF};
    vecs[2] = '{3'd5, 3'd5, 3'd7, 1, 1, 16'h1234, 3, 8'hEF, 8'hEF, 0, 0, 16'h0000, 1, 0, 3'd7, 8'hA7, 3'd0, 8'hA0};
    vecs[3] = '{3'd0, 3'd7, 3'd1, 0, 1, 16'h0000, 0, 8'hA0, 8'hA7, 0, 0, 16'h0000, 0, 1, 3'd1, 8'hA1, 3'd0, 8'hA0};
    vecs[4] = '{3'd1, 3'd6, 3'd6, 0, 0, 16'h00FF, 1, 8'hA1, 8'hA6, 0, 0, 16'h0000, 0, 0, 3'd6, 8'hA6, 3'd7, 8'hA7};
    vecs[5] = '{3'd3, 3'd4, 3'd0, 0, 1, 16'hABCD, 1, 8'h22, 8'hBE, 1, 0, 16'h00CD, 0, 0, 3'd0, 8'hCD, 3'd1, 8'hA1};
    vecs[6] = '{3'd7, 3'd0, 3'd6, 1, 1, 16'h5A5B, 2, 8'hA7, 8'hCD, 1, 1, 16'h5A5B, 0, 0, 3'd6, 8'h5A, 3'd7, 8'h5B};
    vecs[7] = '{3'd6, 3'd7, 3'd7, 1, 0, 16'h0001, 1, 8'h5A, 8'h5B, 0, 0, 16'h0000, 0, 0, 3'd7, 8'h5B, 3'd0, 8'hCD};
    vecs[8] = '{3'd1, 3'd2, 3'd2, 0, 1, 16'h0077, 16, 8'hA1, 8'h11, 1, 0, 16'h0077, 0, 0, 3'd2, 8'h77, 3'd3, 8'h22};

    reset        = 1'b1;
    rf_init      = 1'b1;
    req_valid    = 1'b0;
    req_rs1      = '0;
    req_rs2      = '0;
    req_rd       = '0;
    req_wide     = 1'b0;
    req_wb_en    = 1'b0;
    result_valid = 1'b0;
    result_data  = '0;
    repeat (2) @(negedge clk);
    check_reset("por");
    reset   = 1'b0;
    rf_init = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset while waiting for the ALU, then a late result that must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_rs1 = 3'd2; req_rs2 = 3'd3; req_rd = 3'd3;
    req_wide  = 1'b0; req_wb_en = 1'b1; result_data = 16'h00EE;
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        req_valid = 1'b0;
        seen = op_valid;
      end
      check("rstA op_valid seen", 32'(seen), 32'd1);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset("rstA");
    result_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      result_valid = 1'b0;
      check($sformatf("rstA c%0d rf_r_w", c), 32'(rf_r_w), 32'd1);
      check($sformatf("rstA c%0d done", c), 32'(done), 32'd0);
    end
    check("rstA r3 kept", 32'(regs[3]), 32'h22);

    // Back-to-back: req_valid held high, first op has no writeback.
    @(negedge clk);
    req_valid = 1'b1; req_rs1 = 3'd2; req_rs2 = 3'd3; req_rd = 3'd5;
    req_wide  = 1'b0; req_wb_en = 1'b0; result_data = 16'h0055;
    @(negedge clk);                                    // READ
    check("b2b c1 ready", 32'(req_ready), 32'd0);
    @(negedge clk);                                    // ISSUE
    check("b2b c2 op_valid", 32'(op_valid), 32'd1);
    check("b2b c2 op_a", 32'(op_a), 32'h77);
    check("b2b c2 op_b", 32'(op_b), 32'h22);
    @(negedge clk);                                    // WAIT
    check("b2b c3 rf_r_w", 32'(rf_r_w), 32'd1);
    result_valid = 1'b1;
    @(negedge clk);                                    // IDLE, done of first op
    result_valid = 1'b0;
    check("b2b c4 done", 32'(done), 32'd1);
    check("b2b c4 err_pair", 32'(err_pair), 32'd0);
    check("b2b c4 ready", 32'(req_ready), 32'd1);
    check("b2b c4 rf_r_w", 32'(rf_r_w), 32'd1);
    check("b2b c4 r5 kept", 32'(regs[5]), 32'hEF);
    req_rs1 = 3'd4; req_rs2 = 3'd5; req_rd = 3'd3; req_wb_en = 1'b1;
    result_data = 16'h1299;
    @(negedge clk);                                    // READ of second op
    check("b2b c5 accepted", 32'(req_ready), 32'd0);
    check("b2b c5 done", 32'(done), 32'd0);
    result_valid = 1'b1;                               // stray pulse
    @(negedge clk);                                    // ISSUE
    result_valid = 1'b0;
    check("b2b c6 op_valid", 32'(op_valid), 32'd1);
    check("b2b c6 op_a", 32'(op_a), 32'hBE);
    check("b2b c6 op_b", 32'(op_b), 32'hEF);
    @(negedge clk);                                    // WAIT
    check("b2b c7 rf_r_w", 32'(rf_r_w), 32'd1);
    check("b2b c7 done", 32'(done), 32'd0);
    result_valid = 1'b1;
    @(negedge clk);                                    // WRITE
    result_valid = 1'b0;
    req_valid    = 1'b0;
    check("b2b c8 rf_r_w", 32'(rf_r_w), 32'd0);
    check("b2b c8 rd_addr", 32'(rf_rd_addr), 32'd3);
    check("b2b c8 rd_data", 32'(rf_rd_data), 32'h0099);
    check("b2b c8 length", 32'(rf_input_length), 32'd0);
    @(negedge clk);                                    // IDLE, done
    check("b2b c9 done", 32'(done), 32'd1);
    check("b2b c9 rf_r_w", 32'(rf_r_w), 32'd1);
    check("b2b c9 r3", 32'(regs[3]), 32'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
